// File: rtl/mm_engine_param.sv
// Parametrised signed matrix-multiply engine: C = A x B, streamed through a valid/ready write port.
// Optional MM_SAT_EN clamps results to the signed OW range instead of truncating.
module mm_engine_param #(
    parameter int DW   = 20,
    parameter int IW   = 20,
    parameter int ACCW = 48,
    parameter int OW   = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          trans_b,
    output logic          mem_rd,
    output logic [1:0]    mem_sel,
    output logic [IW-1:0] mem_i,
    output logic [IW-1:0] mem_j,
    input  logic [DW-1:0] rd_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [IW-1:0] wr_row,
    output logic [IW-1:0] wr_col,
    output logic [OW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, HDR, FETCH_A, FETCH_B, ACC_LAST, WRITE, DONE} state_t;

    state_t                  state, state_nx;
    logic [1:0]              h;
    logic [IW-1:0]           dim_r, dim_k, dim_c;
    logic [IW-1:0]           r, k, c;
    logic signed [ACCW-1:0]  acc;
    logic signed [DW-1:0]    a_reg;
    logic                    tb_reg;
    logic                    err_reg;

    logic [IW-1:0]           hdr_val;
    logic                    hdr_zero;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic                    last_k, last_c, last_r;
    logic [OW-1:0]           res;

    assign hdr_val  = IW'(rd_data);
    // C is still on rd_data during h=3, so it is tested directly rather than from dim_c
    assign hdr_zero = (dim_r == '0) || (dim_k == '0) || (hdr_val == '0);
    assign prod     = (2*DW)'(a_reg) * (2*DW)'($signed(rd_data));
    assign prod_ext = ACCW'(prod);
    assign last_k   = (k == dim_k - IW'(1));
    assign last_c   = (c == dim_c - IW'(1));
    assign last_r   = (r == dim_r - IW'(1));

`ifdef MM_SAT_EN
    localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};
    logic [ACCW-OW:0] top;
    assign top = acc[ACCW-1:OW-1];
    always_comb begin
        if (top == '0 || top == '1)
            res = acc[OW-1:0];
        else if (acc[ACCW-1])
            res = MINV;
        else
            res = MAXV;
    end
`else
    assign res = acc[OW-1:0];
`endif

    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_sel  = 2'd0;
        mem_i    = '0;
        mem_j    = '0;
        case (state)
            IDLE: if (start) state_nx = HDR;
            HDR: begin
                if (h != 2'd3) begin
                    mem_rd = 1'b1;
                    mem_i  = IW'(h);
                end else begin
                    state_nx = hdr_zero ? DONE : FETCH_A;
                end
            end
            FETCH_A: begin
                mem_rd   = 1'b1;
                mem_sel  = 2'd1;
                mem_i    = r;
                mem_j    = k;
                state_nx = FETCH_B;
            end
            FETCH_B: begin
                mem_rd   = 1'b1;
                mem_sel  = 2'd2;
                mem_i    = tb_reg ? c : k;
                mem_j    = tb_reg ? k : c;
                state_nx = last_k ? ACC_LAST : FETCH_A;
            end
            ACC_LAST: state_nx = WRITE;
            WRITE: if (wr_ready) state_nx = (last_r && last_c) ? DONE : FETCH_A;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            h       <= '0;
            dim_r   <= '0;
            dim_k   <= '0;
            dim_c   <= '0;
            r       <= '0;
            k       <= '0;
            c       <= '0;
            acc     <= '0;
            a_reg   <= '0;
            tb_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        tb_reg  <= trans_b;
                        err_reg <= 1'b0;
                        h       <= '0;
                    end
                end
                HDR: begin
                    h <= h + 2'd1;
                    case (h)
                        2'd1: dim_r <= hdr_val;
                        2'd2: dim_k <= hdr_val;
                        2'd3: begin
                            dim_c <= hdr_val;
                            if (hdr_zero) begin
                                err_reg <= 1'b1;
                            end else begin
                                r <= '0;
                                c <= '0;
                                k <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
                // rd_data here is the B element fetched for k-1
                FETCH_A: acc <= (k == '0) ? '0 : acc + prod_ext;
                FETCH_B: begin
                    a_reg <= $signed(rd_data);
                    if (!last_k) k <= k + IW'(1);
                end
                ACC_LAST: acc <= acc + prod_ext;
                WRITE: begin
                    if (wr_ready) begin
                        k <= '0;
                        if (last_c) begin
                            c <= '0;
                            r <= r + IW'(1);
                        end else begin
                            c <= c + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_valid = (state == WRITE);
    assign wr_row   = wr_valid ? r : '0;
    assign wr_col   = wr_valid ? c : '0;
    assign wr_data  = wr_valid ? res : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = err_reg;

endmodule
